// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Purpose  : Shares one backing-memory port between the instruction cache and
//            the data cache. Serialises icache line reads, dcache miss reads
//            and dcache dirty write-backs. The fixed memory read delay is
//            modelled with an internal counter. Captured read data goes back
//            to the winning requester together with a one-cycle acknowledge.
// Ports    : clk, rst (async, active-low)
//            icache : i_rd, i_addr -> i_ack, i_rdata
//            dcache : d_rd, d_raddr -> d_rack, d_rdata
//                     d_wr, d_waddr, d_wdata -> d_wack
//            memory : mem_addr, mem_wdata, mem_rden, mem_wren <- mem_rdata
//            status : busy (high whenever the FSM is not idle)
// Options  : ARB_ROUND_ROBIN_EN - alternate the read grant when both caches
//            request together. The default build uses fixed priority
//            d_wr > d_rd > i_rd.
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int MEM_LAT = 10,
    parameter int AW      = 16,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_rd,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_rd,
    input  logic [AW-1:0] d_raddr,
    output logic          d_rack,
    output logic [DW-1:0] d_rdata,
    input  logic          d_wr,
    input  logic [AW-1:0] d_waddr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_wack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_rden,
    output logic          mem_wren,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic       c_ICACHE   = 1'b0;
    localparam logic       c_DCACHE   = 1'b1;
    localparam logic [7:0] c_LAST_CNT = 8'(MEM_LAT - 1);
`ifdef ARB_ROUND_ROBIN_EN
    localparam logic       c_RR_EN    = 1'b1;
`else
    localparam logic       c_RR_EN    = 1'b0;
`endif

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_cnt;
    logic          r_owner;
    logic          r_last_grant;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_rd_pending;
    logic          w_both_rd;
    logic          w_grant_d;
    logic          w_read_done;

    assign w_rd_pending = i_rd | d_rd;
    assign w_both_rd    = i_rd & d_rd;
    assign w_read_done  = (r_cnt == c_LAST_CNT);

    // Read grant (meaningful only in IDLE with a read pending). On a tie the
    // round-robin build hands the grant to whoever was not served last; the
    // fixed build always favours the dcache.
    always_comb begin
        w_grant_d = d_rd;
        if (w_both_rd) begin
            w_grant_d = c_RR_EN ? (r_last_grant == c_ICACHE) : 1'b1;
        end
    end

    // Next state and Moore outputs
    always_comb begin
        w_state_nxt = r_state;
        i_ack       = 1'b0;
        d_rack      = 1'b0;
        d_wack      = 1'b0;
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (d_wr) begin
                    w_state_nxt = S_WRITE;
                end else if (w_rd_pending) begin
                    w_state_nxt = S_READ;
                end
            end
            S_WRITE: begin
                mem_wren    = 1'b1;
                d_wack      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_READ: begin
                mem_rden = 1'b1;
                if (w_read_done) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                i_ack       = (r_owner == c_ICACHE);
                d_rack      = (r_owner == c_DCACHE);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_owner      <= c_ICACHE;
            r_last_grant <= c_ICACHE;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (d_wr) begin
                        r_mem_addr  <= d_waddr;
                        r_mem_wdata <= d_wdata;
                    end else if (w_rd_pending) begin
                        r_owner    <= w_grant_d;
                        r_mem_addr <= w_grant_d ? d_raddr : i_addr;
                        r_cnt      <= 8'd0;
                    end
                end
                S_READ: begin
                    // Last delay cycle: memory data is valid, hand it over.
                    if (w_read_done) begin
                        if (r_owner == c_DCACHE) begin
                            r_d_rdata <= mem_rdata;
                        end else begin
                            r_i_rdata <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_last_grant <= r_owner;
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;

endmodule
`default_nettype wire

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single backing memory port between the instruction cache and the data cache.
- Serialises icache line reads, dcache miss reads and dcache dirty write-backs.
- Models the fixed memory read delay with an internal counter, captures read data and returns it to the winning requester with a one-cycle acknowledge pulse.
- Sits between both caches and the memory model in the cached RV32I core.

Parameters:
- MEM_LAT, 10, memory read delay in cycles. Legal range 1..255.
- AW, 16, address width.
- DW, 32, data width.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
i_rd  in  1  icache read request, level, held until i_ack
i_addr  in  AW  icache read address
i_ack  out  1  one-cycle pulse, i_rdata valid
i_rdata  out  DW  read data to icache
d_rd  in  1  dcache read request, level, held until d_rack
d_raddr  in  AW  dcache read address
d_rack  out  1  one-cycle pulse, d_rdata valid
d_rdata  out  DW  read data to dcache
d_wr  in  1  dcache write-back request, level, held until d_wack
d_waddr  in  AW  write-back address
d_wdata  in  DW  write-back data
d_wack  out  1  one-cycle pulse, write accepted
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
mem_rden  out  1  memory read enable
mem_wren  out  1  memory write enable
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, last_grant=ICACHE. All outputs 0: i_ack, d_rack, d_wack, i_rdata, d_rdata, mem_addr, mem_wdata, mem_rden, mem_wren, busy.
- Reset asserted mid-transaction aborts it. No ack is issued; the requester re-requests after reset.
- States: IDLE, WRITE, READ, RESP.
- IDLE, arbitration on sampled requests:
  - d_wr wins over everything. Latch d_waddr/d_wdata, go to WRITE.
  - Otherwise, if any read is pending: latch the address and an owner bit, counter=0, go to READ. Base priority is d_rd over i_rd.
  - No request: stay in IDLE.
- WRITE (exactly 1 cycle): mem_wren=1, mem_addr/mem_wdata = latched values, d_wack=1 in the same cycle. Next state IDLE.
- READ: mem_rden=1 and mem_addr=latched address for every READ cycle. counter increments each cycle.
  - When counter==MEM_LAT-1: register mem_rdata into the owner's rdata register, go to RESP.
  - READ lasts exactly MEM_LAT cycles.
- RESP (1 cycle): pulse i_ack or d_rack according to the owner bit. Update last_grant to the owner. Requests are not sampled. Next state IDLE.
- Latency: a read first seen in IDLE at cycle T is acked at T+MEM_LAT+1. A write seen at T is acked at T+1.
- Requesters drop the request the cycle after the ack. A request still high when IDLE is re-entered is served as a new request.
- i_rdata and d_rdata hold their value until the next read for the same owner.
- mem_addr and mem_wdata hold their last value in IDLE. mem_rden and mem_wren are 0 in IDLE and RESP.
- Request inputs are only sampled in IDLE. Changes during WRITE, READ or RESP are ignored.
- counter is 8 bits wide and is not incremented past MEM_LAT-1.
- MEM_LAT=1: READ lasts one cycle, ack at T+2.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when i_rd and d_rd are both pending in IDLE (and d_wr=0), the read grant goes to the requester that is not last_grant. d_wr keeps absolute priority.
- Not defined: fixed priority d_wr > d_rd > i_rd. last_grant is still maintained but unused.

Test Plan:
- Reset → all outputs 0 and busy=0. Release, then i_rd=1, i_addr=0x0040, memory returns 0xDEADBEEF → mem_rden high 10 cycles, i_ack pulses at T+11 with i_rdata=0xDEADBEEF.
- d_wr=1, d_waddr=0x1234, d_wdata=0xCAFEF00D while d_rd=1 and i_rd=1 → WRITE first: mem_wren pulse with that addr/data and d_wack at T+1. The d_rd read then starts at T+2.
- i_rd and d_rd held high together for two transactions, no macro → both grants go to dcache (d_rack twice) before i_ack. With ARB_ROUND_ROBIN_EN → grant order d, i (last_grant reset to ICACHE).
- Request toggles during READ (i_rd dropped and re-raised, d_wr raised at cycle T+3) → current read completes unchanged. d_wr is served only after RESP.
- rst pulled low at T+5 of a read → outputs 0 immediately, no i_ack. After release with the request re-raised, a full MEM_LAT read completes.
- Rebuild with MEM_LAT=1 → read acked at T+2; back-to-back reads acked every 3 cycles.
